account_manager: RTL and testbench
==================================

Name: account_manager

Overview:
- Parametrised successor to the single-cycle card handler.
- Owns the on-chip account store (password, balance, lock flag per user).
- Runs a card session FSM: card validation, password verification with a bounded retry budget, balance read-out and write-back.
- Sits between the card reader/keypad front end and the transaction unit.
- The store is provisioned through a write port, not by file load, so it is synthesisable.

Parameters:
- CARD_W, 3, card number width
- PSW_W, 4, password width
- BAL_W, 20, balance width
- USERS_NUM, 8, number of accounts (≤ 2**CARD_W); card_number ≥ USERS_NUM is invalid
- MAX_TRIES, 3, password attempts per session (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low, sampled on rising clk
- card_in  in  1  card present level
- card_number  in  CARD_W  card id, sampled on session start
- password_input  in  PSW_W  entered password
- psw_valid  in  1  one-cycle strobe: password_input is valid
- op_done  in  1  one-cycle strobe: commit updated_balance
- updated_balance  in  BAL_W  new balance from transaction unit
- prov_we  in  1  provisioning write enable
- prov_card  in  CARD_W  provisioning target account
- prov_psw  in  PSW_W  provisioning password
- prov_balance  in  BAL_W  provisioning balance
- balance  out  BAL_W  balance of the authenticated account, else 0
- auth_ok  out  1  level: session authenticated
- wrong_psw  out  1  one-cycle pulse per failed attempt
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts
- invalid_card  out  1  one-cycle pulse: card_number out of range
- card_locked  out  1  level: presented card is locked (feature only, else tied 0)

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all outputs 0; all passwords, balances and lock flags 0. Reset mid-session aborts the session with no write-back.
- All outputs are registered and change one cycle after the causing input edge.
- States: IDLE, VERIFY, READY, EJECT.
- IDLE:
  - prov_we=1 with prov_card<USERS_NUM writes password and balance and clears the lock flag. prov_we is ignored in other states and when out of range.
  - If card_in=1 and prov_we=1 in the same cycle, provisioning wins and the session starts next cycle.
  - card_in=1 with card_number≥USERS_NUM: pulse invalid_card, go to EJECT.
  - card_in=1 with a valid card: latch card_number as cur_card, tries_left=MAX_TRIES, go to VERIFY.
- VERIFY:
  - card_in=0 → IDLE, tries_left=0.
  - psw_valid with a match → READY; auth_ok=1; balance=stored balance of cur_card.
  - psw_valid with a mismatch → wrong_psw pulse; tries_left decrements. When it reaches 0 → EJECT.
  - Without psw_valid: hold.
- READY:
  - op_done → balance_reg[cur_card] and balance output take updated_balance; stay in READY.
  - card_in=0 → IDLE; auth_ok=0, balance=0.
  - op_done and card_in=0 in the same cycle: the write commits, then IDLE.
  - psw_valid is ignored.
- EJECT: wait for card_in=0 → IDLE; clear card_locked. No repeated invalid_card pulses while the card stays inserted.
- Balance arithmetic lives in the transaction unit; this block stores updated_balance verbatim (BAL_W bits, no saturation).

Optional Feature:
- Macro ACCOUNT_LOCK_EN.
- Defined:
  - Exhausting tries sets the persistent lock flag of cur_card.
  - A later insertion of a locked valid card asserts card_locked and goes to EJECT without VERIFY.
  - Only reset or provisioning clears the flag.
- Undefined: no lock flags; card_locked is constant 0; a new session always gets MAX_TRIES attempts.

Decomposition:
- Shared package atm_pkg holds:
  - state encoding (IDLE=0, VERIFY=1, READY=2, EJECT=3)
  - default width constants CARD_W/PSW_W/BAL_W
  - tries-counter width function
- Sub-module account_store holds:
  - password/balance/lock arrays with synchronous active-low clear
  - one combinational read port indexed by cur_card or card_number
  - one write port muxed between provisioning and op_done commit
  - lock-set input

Test Plan:
- Provision card 2 (psw 4'b1010, bal 500); insert card 2; psw_valid with 1010 → auth_ok=1, balance=500, tries_left=3.
- Authenticated card 2; op_done with updated_balance=350; remove and reinsert; authenticate → balance=350.
- Insert card 2; enter 3 wrong passwords → three wrong_psw pulses, tries_left 2,1,0, EJECT, auth_ok stays 0. With ACCOUNT_LOCK_EN, reinsert → card_locked=1 and the correct password is ignored.
- USERS_NUM=6; insert card 7 and hold card_in for 5 cycles → exactly one invalid_card pulse; IDLE after card_in=0.
- In READY, assert op_done (updated_balance=100) with card_in=0 in the same cycle → store=100, IDLE, balance=0.
- Assert rst=0 in READY before op_done → all outputs 0, balance store cleared to 0, next insertion starts in VERIFY.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the account manager: session state encoding,
// default field widths and the tries-counter width helper.
package atm_pkg;

  // Session states; the encoding is visible to software debug taps.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VERIFY = 2'd1,
    READY  = 2'd2,
    EJECT  = 2'd3
  } state_t;

  localparam int DEF_CARD_W = 3;
  localparam int DEF_PSW_W  = 4;
  localparam int DEF_BAL_W  = 20;

  // Width needed to hold the values 0..max_tries.
  function automatic int tries_w(input int max_tries);
    return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
  endfunction

endpackage

// File: rtl/account_store.sv
// On-chip account store: password, balance and (with ACCOUNT_LOCK_EN) a
// lock flag per user. One combinational read port, one write port, one
// lock-set strobe that targets the account on the read port.
// Reset clears every entry synchronously.
module account_store
  import atm_pkg::*;
#(
  parameter int CARD_W    = DEF_CARD_W,
  parameter int PSW_W     = DEF_PSW_W,
  parameter int BAL_W     = DEF_BAL_W,
  parameter int USERS_NUM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CARD_W-1:0] rd_idx,
  output logic [PSW_W-1:0]  rd_psw,
  output logic [BAL_W-1:0]  rd_bal,
  output logic              rd_lock,
  input  logic              wr_en,
  input  logic [CARD_W-1:0] wr_idx,
  input  logic              wr_psw_en,
  input  logic [PSW_W-1:0]  wr_psw,
  input  logic [BAL_W-1:0]  wr_bal,
  input  logic              lock_set
);

  localparam logic [CARD_W:0] USERS_L = (CARD_W + 1)'(USERS_NUM);

  logic [PSW_W-1:0] psw_mem [USERS_NUM];
  logic [BAL_W-1:0] bal_mem [USERS_NUM];
  logic             rd_ok;

  // Indices past the last account read as an empty entry.
  assign rd_ok  = {1'b0, rd_idx} < USERS_L;
  assign rd_psw = rd_ok ? psw_mem[rd_idx] : '0;
  assign rd_bal = rd_ok ? bal_mem[rd_idx] : '0;

  // Password/balance storage; password only written on provisioning.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < USERS_NUM; i++) begin
        psw_mem[i] <= '0;
        bal_mem[i] <= '0;
      end
    end else if (wr_en) begin
      bal_mem[wr_idx] <= wr_bal;
      if (wr_psw_en) psw_mem[wr_idx] <= wr_psw;
    end
  end

`ifdef ACCOUNT_LOCK_EN
  logic lock_mem [USERS_NUM];

  assign rd_lock = rd_ok & lock_mem[rd_idx];

  // Lock flags: provisioning clears, exhausted retries set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < USERS_NUM; i++) lock_mem[i] <= 1'b0;
    end else begin
      if (wr_en && wr_psw_en) lock_mem[wr_idx] <= 1'b0;
      if (lock_set && rd_ok)  lock_mem[rd_idx] <= 1'b1;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = lock_set;
  assign rd_lock     = 1'b0;
`endif

endmodule

// File: rtl/account_manager.sv
// Card session controller with an on-chip account store.
// Flow: IDLE -> VERIFY (bounded password retries) -> READY (balance
// read-out, write-back on op_done) -> IDLE; bad or exhausted cards park
// in EJECT until removed.
// Optional feature macro ACCOUNT_LOCK_EN: exhausting retries locks the
// account until reset or re-provisioning.
module account_manager
  import atm_pkg::*;
#(
  parameter int CARD_W    = DEF_CARD_W,
  parameter int PSW_W     = DEF_PSW_W,
  parameter int BAL_W     = DEF_BAL_W,
  parameter int USERS_NUM = 8,
  parameter int MAX_TRIES = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         card_in,
  input  logic [CARD_W-1:0]            card_number,
  input  logic [PSW_W-1:0]             password_input,
  input  logic                         psw_valid,
  input  logic                         op_done,
  input  logic [BAL_W-1:0]             updated_balance,
  input  logic                         prov_we,
  input  logic [CARD_W-1:0]            prov_card,
  input  logic [PSW_W-1:0]             prov_psw,
  input  logic [BAL_W-1:0]             prov_balance,
  output logic [BAL_W-1:0]             balance,
  output logic                         auth_ok,
  output logic                         wrong_psw,
  output logic [tries_w(MAX_TRIES)-1:0] tries_left,
  output logic                         invalid_card,
  output logic                         card_locked
);

  localparam int              TW         = tries_w(MAX_TRIES);
  localparam logic [CARD_W:0] USERS_L    = (CARD_W + 1)'(USERS_NUM);
  localparam logic [TW-1:0]   TRIES_INIT = TW'(MAX_TRIES);
  localparam logic [TW-1:0]   TRIES_ONE  = TW'(1);

  state_t            state;
  logic [CARD_W-1:0] cur_card;

  logic [CARD_W-1:0] rd_idx;
  logic [PSW_W-1:0]  rd_psw;
  logic [BAL_W-1:0]  rd_bal;
  logic              rd_lock;
  logic              card_valid;
  logic              prov_hit;
  logic              commit;
  logic              wr_en;
  logic [CARD_W-1:0] wr_idx;
  logic [BAL_W-1:0]  wr_bal;
  logic              psw_match;
  logic              last_try;
  logic              lock_set;

  // In IDLE the store is looked up by the presented card (lock check),
  // afterwards by the latched session card.
  assign rd_idx     = (state == IDLE) ? card_number : cur_card;
  assign card_valid = {1'b0, card_number} < USERS_L;
  assign psw_match  = password_input == rd_psw;
  assign last_try   = tries_left == TRIES_ONE;

  // Provisioning and commit are exclusive by state, so one write port suffices.
  assign prov_hit = (state == IDLE) && prov_we && ({1'b0, prov_card} < USERS_L);
  assign commit   = (state == READY) && op_done;
  assign wr_en    = prov_hit | commit;
  assign wr_idx   = prov_hit ? prov_card : cur_card;
  assign wr_bal   = prov_hit ? prov_balance : updated_balance;

`ifdef ACCOUNT_LOCK_EN
  assign lock_set = (state == VERIFY) && card_in && psw_valid && !psw_match && last_try;
`else
  logic unused_lock;
  assign unused_lock = rd_lock;
  assign lock_set    = 1'b0;
`endif

  account_store #(
    .CARD_W    (CARD_W),
    .PSW_W     (PSW_W),
    .BAL_W     (BAL_W),
    .USERS_NUM (USERS_NUM)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (rd_idx),
    .rd_psw    (rd_psw),
    .rd_bal    (rd_bal),
    .rd_lock   (rd_lock),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_psw_en (prov_hit),
    .wr_psw    (prov_psw),
    .wr_bal    (wr_bal),
    .lock_set  (lock_set)
  );

  // Session FSM with registered outputs; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cur_card     <= '0;
      balance      <= '0;
      auth_ok      <= 1'b0;
      wrong_psw    <= 1'b0;
      tries_left   <= '0;
      invalid_card <= 1'b0;
      card_locked  <= 1'b0;
    end else begin
      wrong_psw    <= 1'b0;
      invalid_card <= 1'b0;
      case (state)
        IDLE: begin
          // A provisioning write holds off session start by one cycle.
          if (card_in && !prov_we) begin
            if (!card_valid) begin
              invalid_card <= 1'b1;
              state        <= EJECT;
            end
`ifdef ACCOUNT_LOCK_EN
            else if (rd_lock) begin
              card_locked <= 1'b1;
              state       <= EJECT;
            end
`endif
            else begin
              cur_card   <= card_number;
              tries_left <= TRIES_INIT;
              state      <= VERIFY;
            end
          end
        end
        VERIFY: begin
          if (!card_in) begin
            tries_left <= '0;
            state      <= IDLE;
          end else if (psw_valid) begin
            if (psw_match) begin
              auth_ok <= 1'b1;
              balance <= rd_bal;
              state   <= READY;
            end else begin
              wrong_psw  <= 1'b1;
              tries_left <= tries_left - TRIES_ONE;
              if (last_try) state <= EJECT;
            end
          end
        end
        READY: begin
          // The commit lands in the store even when the card leaves this cycle.
          if (op_done) balance <= updated_balance;
          if (!card_in) begin
            auth_ok    <= 1'b0;
            balance    <= '0;
            tries_left <= '0;
            state      <= IDLE;
          end
        end
        EJECT: begin
          if (!card_in) begin
            card_locked <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_account_manager.sv
// Directed bench for account_manager (USERS_NUM=6). Inputs change 1ns
// after a rising edge; outputs are checked 1ns after the next edge.
module tb_account_manager;

  localparam int CARD_W = 3, PSW_W = 4, BAL_W = 20, USERS_NUM = 6, MAX_TRIES = 3;
  localparam int TW = atm_pkg::tries_w(MAX_TRIES);

  logic              clk = 1'b0;
  logic              rst;
  logic              card_in;
  logic [CARD_W-1:0] card_number;
  logic [PSW_W-1:0]  password_input;
  logic              psw_valid;
  logic              op_done;
  logic [BAL_W-1:0]  updated_balance;
  logic              prov_we;
  logic [CARD_W-1:0] prov_card;
  logic [PSW_W-1:0]  prov_psw;
  logic [BAL_W-1:0]  prov_balance;
  logic [BAL_W-1:0]  balance;
  logic              auth_ok;
  logic              wrong_psw;
  logic [TW-1:0]     tries_left;
  logic              invalid_card;
  logic              card_locked;

  int total = 0;
  int bad   = 0;
  int pulses;

  account_manager #(
    .CARD_W(CARD_W), .PSW_W(PSW_W), .BAL_W(BAL_W),
    .USERS_NUM(USERS_NUM), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_number(card_number),
    .password_input(password_input), .psw_valid(psw_valid),
    .op_done(op_done), .updated_balance(updated_balance),
    .prov_we(prov_we), .prov_card(prov_card), .prov_psw(prov_psw),
    .prov_balance(prov_balance), .balance(balance), .auth_ok(auth_ok),
    .wrong_psw(wrong_psw), .tries_left(tries_left),
    .invalid_card(invalid_card), .card_locked(card_locked)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prov(input int card, input int psw, input int bal);
    prov_we = 1'b1; prov_card = CARD_W'(card); prov_psw = PSW_W'(psw);
    prov_balance = BAL_W'(bal);
    tick();
    prov_we = 1'b0;
  endtask

  task automatic enter(input int psw);
    psw_valid = 1'b1; password_input = PSW_W'(psw);
    tick();
    psw_valid = 1'b0;
  endtask

  task automatic insert(input int card);
    card_in = 1'b1; card_number = CARD_W'(card);
    tick();
  endtask

  task automatic remove();
    card_in = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; card_in = 0; card_number = 0; password_input = 0; psw_valid = 0;
    op_done = 0; updated_balance = 0; prov_we = 0; prov_card = 0; prov_psw = 0;
    prov_balance = 0;
    tick(); tick();
    chk("rst_bal", balance, 0);
    chk("rst_auth", auth_ok, 0);
    chk("rst_tries", tries_left, 0);
    chk("rst_inv", invalid_card, 0);
    chk("rst_lock", card_locked, 0);
    rst = 1'b1;

    // Authenticate card 2
    prov(2, 4'b1010, 500);
    insert(2);
    chk("ins_tries", tries_left, 3);
    chk("ins_auth", auth_ok, 0);
    enter(4'b1010);
    chk("auth_ok", auth_ok, 1);
    chk("auth_bal", balance, 500);
    chk("auth_tries", tries_left, 3);
    enter(4'b0000);
    chk("ready_ignore_psw", wrong_psw, 0);

    // Write-back survives a new session
    op_done = 1'b1; updated_balance = 350;
    tick();
    op_done = 1'b0;
    chk("commit_bal", balance, 350);
    remove();
    chk("rm_auth", auth_ok, 0);
    chk("rm_bal", balance, 0);
    insert(2);
    enter(4'b1010);
    chk("reauth_bal", balance, 350);
    remove();

    // Retry exhaustion
    insert(2);
    for (int i = 0; i < 3; i++) begin
      enter(4'b0101);
      chk("wrong_pulse", wrong_psw, 1);
      chk("wrong_tries", tries_left, 2 - i);
      chk("wrong_auth", auth_ok, 0);
      tick();
      chk("wrong_pulse_end", wrong_psw, 0);
    end
    enter(4'b1010);
    chk("eject_ignore_psw", auth_ok, 0);
    remove();
    insert(2);
`ifdef ACCOUNT_LOCK_EN
    chk("locked_flag", card_locked, 1);
    enter(4'b1010);
    chk("locked_auth", auth_ok, 0);
    remove();
    chk("unlock_on_remove", card_locked, 0);
    prov(2, 4'b1010, 350);
    insert(2);
    chk("reprov_tries", tries_left, 3);
    remove();
`else
    chk("nolock_flag", card_locked, 0);
    chk("nolock_tries", tries_left, 3);
    enter(4'b1010);
    chk("nolock_auth", auth_ok, 1);
    remove();
`endif

    // Out-of-range cards: one pulse only, then IDLE
    card_in = 1'b1; card_number = 3'd7;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (invalid_card) pulses++;
    end
    chk("inv_pulses", pulses, 1);
    remove();
    insert(6);
    chk("inv_boundary", invalid_card, 1);
    remove();
    insert(5);
    chk("valid_boundary_inv", invalid_card, 0);
    chk("valid_boundary_tries", tries_left, 3);
    remove();

    // Provisioning wins over same-cycle insertion
    prov_we = 1'b1; prov_card = 3'd5; prov_psw = 4'b0011; prov_balance = 77;
    card_in = 1'b1; card_number = 3'd5;
    tick();
    prov_we = 1'b0;
    chk("prov_wins", tries_left, 0);
    tick();
    chk("prov_then_start", tries_left, 3);
    enter(4'b0011);
    chk("prov_bal", balance, 77);

    // op_done and removal together
    op_done = 1'b1; updated_balance = 100; card_in = 1'b0;
    tick();
    op_done = 1'b0;
    chk("same_cyc_bal", balance, 0);
    chk("same_cyc_auth", auth_ok, 0);
    insert(5);
    enter(4'b0011);
    chk("same_cyc_store", balance, 100);

    // Reset mid-session clears the store
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_bal", balance, 0);
    chk("mid_rst_auth", auth_ok, 0);
    chk("mid_rst_tries", tries_left, 0);
    tick();
    chk("post_rst_verify", tries_left, 3);
    enter(4'b0000);
    chk("post_rst_auth", auth_ok, 1);
    chk("post_rst_bal", balance, 0);

    // Provisioning outside IDLE is ignored
    prov(5, 4'b1111, 999);
    remove();
    insert(5);
    enter(4'b0000);
    chk("prov_ignored_auth", auth_ok, 1);
    chk("prov_ignored_bal", balance, 0);
    remove();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
